bz_worm_arbiter: RTL and testbench
==================================

# bz_worm_arbiter

Round-robin, worm-atomic arbiter that merges NPORTS incoming router flit FIFOs into one outbound flit FIFO. It feeds the BZ deserializer path, so a worm (header flit plus data flits up to and including the flit with its tail bit set) from one source is never interleaved with another. Inputs and output are show-ahead FIFO interfaces carrying 11-bit flits: [10:1] payload, [0] tail.

## Interface
Parameters:
- NPORTS, 4, number of input flit FIFOs (2..8)
- NFLIT, 11, flit width; bit 0 is the tail bit

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- in_isempty  input  NPORTS  per-port FIFO empty
- in_data  input  NPORTS×NFLIT  per-port show-ahead FIFO head flit
- in_rdreq  output  NPORTS  per-port pop; at most one bit high
- port_en  input  NPORTS  per-port arbitration enable
- out_isfull  input  1  output FIFO full
- out_data  output  NFLIT  flit to output FIFO
- out_wrreq  output  1  push to output FIFO
- busy  output  1  high while a worm is granted
- grant_id  output  $clog2(NPORTS)  currently or last granted port

## Operation
- FSM states: IDLE, FWD.
- IDLE: pick the first port p with port_en[p] && !in_isempty[p], searching from ptr+1 upward with wrap.
  - If such a port is found: grant_id <= p, go to FWD.
  - If none is found: stay in IDLE.
  - No flit moves in IDLE.
- FWD: xfer = !in_isempty[grant_id] && !out_isfull.
  - in_rdreq[grant_id] = xfer and out_wrreq = xfer, combinational.
  - out_data = in_data[grant_id] when xfer, else 0.
- Tail flit transferred (xfer && in_data[grant_id][0]): ptr <= grant_id, go to IDLE.
- Grant held while the granted input is empty mid-worm. Other ports wait; there is no preemption and no timeout.
- port_en is sampled only in IDLE. Deasserting it for the granted port mid-worm has no effect until that worm's tail.
- A flit is never dropped or duplicated. A flit is written to the output only in a cycle where it is also popped from the input.
- busy = (state == FWD).

## Timing
- Reset (reset low at a clk edge): state IDLE, ptr = NPORTS-1 so port 0 has first priority, grant_id = 0.
  - in_rdreq, out_wrreq, out_data and busy are all 0 from the following cycle.
- Reset mid-worm abandons the worm. The remainder of the worm is treated as a new worm when it is next granted; upstream flushes are not this block's concern.
- Arbitration latency: 1 cycle from the IDLE decision to the first transfer in FWD.
- Each worm costs one bubble cycle (IDLE) after its tail.
- Throughput: 1 flit/clk inside a worm when the input is non-empty and the output is not full.
- out_isfull and in_isempty act combinationally in the same cycle; there is no skid buffer.
- Single-flit worm (header with tail set): IDLE → FWD → IDLE; 1 transfer.

## Structure
- Shared package bz_router_pkg:
  - NFLIT = 11, TAIL_BIT = 0
  - typedef logic [NFLIT-1:0] flit_t
  - state enum {IDLE, FWD}
- Sub-module bz_rr_pick: combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: found flag and index.
  - Reused by future core-side arbiters.

## Test plan
- Single worm, port 0: flits 0x000, 0x3FE, 0x554, 0x2A9 queued → 4 writes in order on consecutive cycles after 1 idle cycle; busy falls after 0x2A9; grant_id = 0.
- Contention, ports 0 and 2 each with a 3-flit worm → port 0 worm fully written, one bubble, then port 2 worm. Repeated after that → port 2 first next round if it alone is requesting, otherwise port 0 after ptr = 2 wraps.
- Backpressure: out_isfull high for 3 cycles during flit 2 → zero rdreq/wrreq in those cycles, flit 2 written on the first non-full cycle, total writes equal flits queued.
- Input starvation: granted port empties after 2 of 4 flits while port 1 holds data → grant stays, port 1 gets no rdreq; remaining flits complete when refilled, then port 1 granted.
- port_en: port 1 disabled with data → never granted; disable granted port 3 mid-worm → worm completes to tail.
- Reset mid-worm (reset low 1 cycle after flit 2) → all outputs 0 next cycle; after release, port 0 gets priority over port 1 when both request.

Source files
------------

// File: rtl/bz_router_pkg.sv
// Shared router definitions: flit layout and the worm-forwarding state encoding.
package bz_router_pkg;

   localparam int NFLIT    = 11;
   localparam int TAIL_BIT = 0;

   typedef logic [NFLIT-1:0] flit_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FWD  = 1'b1
   } state_t;

endpackage

// File: rtl/bz_worm_arbiter_if.sv
// Flit-FIFO side of the worm arbiter: NPORTS show-ahead inputs, one output FIFO, status.
// Handshake: a flit moves on an input when in_rdreq[p] is high and in_isempty[p] is low in the same
// cycle; it moves to the output when out_wrreq is high, which is only ever asserted with out_isfull low.
interface bz_worm_arbiter_if
   import bz_router_pkg::*;
#(
   parameter int NPORTS = 4,
   parameter int NFLIT  = 11
);

   localparam int GW = $clog2(NPORTS);

   logic [NPORTS-1:0]            in_isempty;
   logic [NPORTS-1:0][NFLIT-1:0] in_data;
   logic [NPORTS-1:0]            in_rdreq;
   logic [NPORTS-1:0]            port_en;
   logic                         out_isfull;
   logic [NFLIT-1:0]             out_data;
   logic                         out_wrreq;
   logic                         busy;
   logic [GW-1:0]                grant_id;
   state_t                       dbg_state;

   modport master (
      input  in_isempty, in_data, port_en, out_isfull,
      output in_rdreq, out_data, out_wrreq, busy, grant_id, dbg_state
   );

   modport slave (
      output in_isempty, in_data, port_en, out_isfull,
      input  in_rdreq, out_data, out_wrreq, busy, grant_id, dbg_state
   );

endinterface

// File: rtl/bz_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after i_ptr, wrapping.
module bz_rr_pick #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic         o_found,
   output logic [W-1:0] o_idx
);

   always_comb begin
      logic [W-1:0] w_cand;
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      // k = N lands back on i_ptr itself, so the last winner is considered last.
      for (int k = 1; k <= N; k++) begin
         w_cand = W'((int'(i_ptr) + k) % N);
         if (!o_found && i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/bz_worm_arbiter.sv
// Worm-atomic round-robin merge of NPORTS flit FIFOs into one output FIFO.
// A granted worm runs to its tail flit with no preemption; one IDLE cycle separates worms.
module bz_worm_arbiter
   import bz_router_pkg::*;
#(
   parameter int NPORTS = 4,
   parameter int NFLIT  = 11
) (
   input  logic               clk,
   input  logic               reset,
   bz_worm_arbiter_if.master  io_bus
);

   localparam int GW = $clog2(NPORTS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [GW-1:0]     r_ptr;
   logic [GW-1:0]     w_ptr_nxt;
   logic [GW-1:0]     r_grant;
   logic [GW-1:0]     w_grant_nxt;

   logic [NPORTS-1:0] w_req;
   logic              w_found;
   logic [GW-1:0]     w_pick;

   logic [NFLIT-1:0]  w_head;
   logic              w_xfer;
   logic [NPORTS-1:0] w_rdreq;
   logic              w_wrreq;
   logic [NFLIT-1:0]  w_out_data;

   // port_en only gates new grants; it is never looked at while a worm is in flight.
   assign w_req  = io_bus.port_en & ~io_bus.in_isempty;
   assign w_head = io_bus.in_data[r_grant];

   bz_rr_pick #(
      .N (NPORTS)
   ) u_pick (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_ptr   <= GW'(NPORTS - 1);
         r_grant <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_grant <= w_grant_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_grant_nxt = r_grant;
      w_xfer      = 1'b0;
      w_rdreq     = '0;
      w_wrreq     = 1'b0;
      w_out_data  = '0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_grant_nxt = w_pick;
               w_state_nxt = FWD;
            end
         end
         FWD: begin
            // Pop and push are the same event: no skid buffer, so a full output stalls the input.
            w_xfer = !io_bus.in_isempty[r_grant] && !io_bus.out_isfull;
            if (w_xfer) begin
               w_rdreq[r_grant] = 1'b1;
               w_wrreq          = 1'b1;
               w_out_data       = w_head;
               if (w_head[TAIL_BIT]) begin
                  w_ptr_nxt   = r_grant;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign io_bus.in_rdreq  = w_rdreq;
   assign io_bus.out_wrreq = w_wrreq;
   assign io_bus.out_data  = w_out_data;
   assign io_bus.busy      = (r_state == FWD);
   assign io_bus.grant_id  = r_grant;
   assign io_bus.dbg_state = r_state;

   a_rdreq_onehot0 : assert property (@(posedge clk) disable iff (!reset)
      $onehot0(w_rdreq));
   a_pop_is_push : assert property (@(posedge clk) disable iff (!reset)
      w_wrreq == (|w_rdreq));
   a_no_write_full : assert property (@(posedge clk) disable iff (!reset)
      !(w_wrreq && io_bus.out_isfull));

endmodule

// File: tb/tb_bz_worm_arbiter.sv
// Directed bench for bz_worm_arbiter: vector table for single worm / backpressure, then
// hand-written contention, starvation, port_en and mid-worm reset sequences.
module tb_bz_worm_arbiter;
   import bz_router_pkg::*;

   localparam int NP = 4;
   localparam int NF = 11;
   localparam int FD = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bz_worm_arbiter_if #(.NPORTS(NP), .NFLIT(NF)) bus ();

   bz_worm_arbiter #(.NPORTS(NP), .NFLIT(NF)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   // Show-ahead input FIFO models
   logic [NF-1:0] fmem [NP][FD];
   int            fhead [NP];
   int            ftail [NP];

   logic [NF-1:0] exp_q [$];
   int            exp_src;
   int            n_pass;
   int            n_total;

   logic [NP-1:0] s_rd;
   logic          s_wr;
   logic [NF-1:0] s_data;
   logic          s_busy;
   logic [1:0]    s_grant;

   typedef struct {
      int          preload;
      logic        isfull;
      logic        exp_wr;
      logic [NF-1:0] exp_data;
      logic        exp_busy;
      logic [1:0]  exp_grant;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      else n_pass++;
   endtask

   task automatic refresh();
      for (int p = 0; p < NP; p++) begin
         bus.in_isempty[p] = (fhead[p] == ftail[p]);
         bus.in_data[p]    = fmem[p][fhead[p] % FD];
      end
   endtask

   task automatic push(input int p, input logic [NF-1:0] f, input bit expect_it);
      fmem[p][ftail[p] % FD] = f;
      ftail[p]++;
      if (expect_it) exp_q.push_back(f);
      refresh();
   endtask

   // One clock: sample at negedge, score writes, then apply pops after the edge.
   task automatic cycle();
      logic [NP-1:0] one;
      logic [NP-1:0] oh;
      one = 1;
      @(negedge clk);
      s_rd    = bus.in_rdreq;
      s_wr    = bus.out_wrreq;
      s_data  = bus.out_data;
      s_busy  = bus.busy;
      s_grant = bus.grant_id;
      if (s_wr) begin
         oh = one << exp_src;
         chk("rdreq_src", 32'(s_rd), 32'(oh));
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL extra_write: got 0x%0h expected no write", s_data);
         end else begin
            chk("wr_data", 32'(s_data), 32'(exp_q.pop_front()));
         end
      end else begin
         chk("quiet_rd_data", {17'd0, s_rd, s_data}, 32'd0);
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (s_rd[p]) begin
            if (fhead[p] == ftail[p]) begin
               n_total++;
               $display("FAIL pop_empty: got pop on port %0d expected none", p);
            end else begin
               fhead[p]++;
            end
         end
      end
      refresh();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      exp_src = 0;
      for (int p = 0; p < NP; p++) begin
         fhead[p] = 0;
         ftail[p] = 0;
         for (int i = 0; i < FD; i++) fmem[p][i] = '0;
      end
      bus.port_en    = '1;
      bus.out_isfull = 1'b0;
      refresh();

      //        preload isfull wr  data      busy grant
      tbl[0]  = '{1, 1'b0, 1'b0, 11'h000, 1'b0, 2'd0};
      tbl[1]  = '{0, 1'b0, 1'b1, 11'h000, 1'b1, 2'd0};
      tbl[2]  = '{0, 1'b0, 1'b1, 11'h3FE, 1'b1, 2'd0};
      tbl[3]  = '{0, 1'b0, 1'b1, 11'h554, 1'b1, 2'd0};
      tbl[4]  = '{0, 1'b0, 1'b1, 11'h2A9, 1'b1, 2'd0};
      tbl[5]  = '{0, 1'b0, 1'b0, 11'h000, 1'b0, 2'd0};
      tbl[6]  = '{2, 1'b0, 1'b0, 11'h000, 1'b0, 2'd0};
      tbl[7]  = '{0, 1'b0, 1'b1, 11'h010, 1'b1, 2'd0};
      tbl[8]  = '{0, 1'b1, 1'b0, 11'h000, 1'b1, 2'd0};
      tbl[9]  = '{0, 1'b1, 1'b0, 11'h000, 1'b1, 2'd0};
      tbl[10] = '{0, 1'b1, 1'b0, 11'h000, 1'b1, 2'd0};
      tbl[11] = '{0, 1'b0, 1'b1, 11'h020, 1'b1, 2'd0};
      tbl[12] = '{0, 1'b0, 1'b1, 11'h030, 1'b1, 2'd0};
      tbl[13] = '{0, 1'b0, 1'b1, 11'h041, 1'b1, 2'd0};
      tbl[14] = '{0, 1'b0, 1'b0, 11'h000, 1'b0, 2'd0};

      do_reset();
      cycle();
      chk("reset_busy", 32'(s_busy), 32'd0);
      chk("reset_grant", 32'(s_grant), 32'd0);
      chk("reset_wr", 32'(s_wr), 32'd0);

      // Single worm and backpressure, port 0
      exp_src = 0;
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].preload == 1) begin
            push(0, 11'h000, 1); push(0, 11'h3FE, 1); push(0, 11'h554, 1); push(0, 11'h2A9, 1);
         end else if (tbl[i].preload == 2) begin
            push(0, 11'h010, 1); push(0, 11'h020, 1); push(0, 11'h030, 1); push(0, 11'h041, 1);
         end
         bus.out_isfull = tbl[i].isfull;
         cycle();
         chk($sformatf("row%0d_wr", i), 32'(s_wr), 32'(tbl[i].exp_wr));
         chk($sformatf("row%0d_data", i), 32'(s_data), 32'(tbl[i].exp_data));
         chk($sformatf("row%0d_busy", i), 32'(s_busy), 32'(tbl[i].exp_busy));
         chk($sformatf("row%0d_grant", i), 32'(s_grant), 32'(tbl[i].exp_grant));
      end
      bus.out_isfull = 1'b0;

      // Contention: ports 0 and 2 from reset priority, then again with ptr = 2 wrapping to 0
      do_reset();
      push(0, 11'h100, 1); push(0, 11'h102, 1); push(0, 11'h105, 1);
      push(2, 11'h200, 1); push(2, 11'h202, 1); push(2, 11'h205, 1);
      exp_src = 0;
      cycle();
      chk("cont_idle_busy", 32'(s_busy), 32'd0);
      repeat (3) cycle();
      chk("cont_grant0", 32'(s_grant), 32'd0);
      cycle();
      chk("cont_bubble_busy", 32'(s_busy), 32'd0);
      exp_src = 2;
      repeat (3) cycle();
      chk("cont_grant2", 32'(s_grant), 32'd2);
      cycle();
      chk("cont_end_busy", 32'(s_busy), 32'd0);
      push(0, 11'h110, 1); push(0, 11'h113, 1);
      push(2, 11'h210, 1); push(2, 11'h213, 1);
      exp_src = 0;
      cycle();
      repeat (2) cycle();
      chk("cont_wrap_grant0", 32'(s_grant), 32'd0);
      cycle();
      exp_src = 2;
      repeat (2) cycle();
      chk("cont_wrap_grant2", 32'(s_grant), 32'd2);
      cycle();

      // Input starvation: port 3 runs dry mid-worm while port 1 waits
      push(3, 11'h300, 1); push(3, 11'h302, 1);
      push(1, 11'h111, 0);
      exp_src = 3;
      cycle();
      repeat (2) cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("starve_busy", 32'(s_busy), 32'd1);
         chk("starve_grant", 32'(s_grant), 32'd3);
      end
      push(3, 11'h304, 1); push(3, 11'h307, 1);
      repeat (2) cycle();
      cycle();
      chk("starve_bubble_busy", 32'(s_busy), 32'd0);
      exp_q.push_back(11'h111);
      exp_src = 1;
      cycle();
      chk("starve_grant1", 32'(s_grant), 32'd1);
      cycle();

      // port_en: port 1 disabled throughout; port 3 disabled mid-worm still finishes
      bus.port_en = 4'b1101;
      push(1, 11'h121, 0);
      push(3, 11'h330, 1); push(3, 11'h332, 1); push(3, 11'h335, 1);
      exp_src = 3;
      cycle();
      cycle();
      bus.port_en = 4'b0101;
      repeat (2) cycle();
      chk("en_tail_grant", 32'(s_grant), 32'd3);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("en_blocked_busy", 32'(s_busy), 32'd0);
      end
      bus.port_en = '1;
      exp_q.push_back(11'h121);
      exp_src = 1;
      cycle();
      cycle();
      chk("en_grant1", 32'(s_grant), 32'd1);
      cycle();

      // Reset mid-worm on port 1; afterwards port 0 wins over the leftover port 1 flit
      push(1, 11'h500, 1); push(1, 11'h502, 1); push(1, 11'h504, 1); push(1, 11'h507, 0);
      exp_src = 1;
      cycle();
      repeat (2) cycle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      push(0, 11'h601, 1);
      exp_q.push_back(11'h507);
      cycle();
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_grant", 32'(s_grant), 32'd0);
      chk("rst_wr", 32'(s_wr), 32'd0);
      exp_src = 0;
      cycle();
      chk("rst_prio_grant0", 32'(s_grant), 32'd0);
      cycle();
      exp_src = 1;
      cycle();
      chk("rst_rest_grant1", 32'(s_grant), 32'd1);
      cycle();

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      for (int p = 0; p < NP; p++)
         chk($sformatf("fifo%0d_drained", p), 32'(ftail[p] - fhead[p]), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
